// File: rtl/alu_seq_unit.sv
// Handshaked 32-bit ALU wrapper: single-cycle logic/arith ops, 1 bit/cycle shifts.
// Optional sticky overflow flag enabled by defining ALU_STICKY_OVF_EN.
module alu_seq_unit #(
   parameter int WIDTH    = 32,
   parameter int OP_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    X,
   input  logic [WIDTH-1:0]    Y,
   input  logic [OP_WIDTH-1:0] op_code,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    Z,
   output logic                equal,
   output logic                overflow,
   output logic                zero
`ifdef ALU_STICKY_OVF_EN
   ,
   output logic                ovf_sticky,
   input  logic                ovf_clr
`endif
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(9);

   // EXEC gives the one-cycle gap between accept and the first shift/result
   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [WIDTH-1:0]    r_x;
   logic [WIDTH-1:0]    r_y;
   logic [OP_WIDTH-1:0] r_op;
   logic [SW-1:0]       r_cnt;
   logic [WIDTH-1:0]    r_z;
   logic                r_eq;
   logic                r_ovf;

   logic [WIDTH-1:0]    w_add;
   logic [WIDTH-1:0]    w_sub;
   logic                w_add_ovf;
   logic                w_sub_ovf;
   logic                w_slt;
   logic                w_is_shift;
   logic [SW-1:0]       w_amt;
   logic [WIDTH-1:0]    w_res;
   logic                w_ovf;
   logic [WIDTH-1:0]    w_shift1;

   assign w_add = r_x + r_y;
   assign w_sub = r_x - r_y;
   assign w_add_ovf = (r_x[WIDTH-1] == r_y[WIDTH-1])
                    & (w_add[WIDTH-1] != r_x[WIDTH-1]);
   assign w_sub_ovf = (r_x[WIDTH-1] != r_y[WIDTH-1])
                    & (w_sub[WIDTH-1] != r_x[WIDTH-1]);
   assign w_slt = $signed(r_x) < $signed(r_y);
   assign w_is_shift = (r_op == OP_SLL) | (r_op == OP_SRL)
                     | (r_op == OP_SRA);
   assign w_amt = r_y[SW-1:0];

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (r_op)
         OP_AND: w_res = r_x & r_y;
         OP_OR:  w_res = r_x | r_y;
         OP_XOR: w_res = r_x ^ r_y;
         OP_NOR: w_res = ~(r_x | r_y);
         OP_ADD: begin
            w_res = w_add;
            w_ovf = w_add_ovf;
         end
         OP_SUB: begin
            w_res = w_sub;
            w_ovf = w_sub_ovf;
         end
         OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
         OP_SLL, OP_SRL, OP_SRA: w_res = r_x;
         default: w_res = '0;
      endcase
   end

   always_comb begin
      w_shift1 = r_z;
      case (r_op)
         OP_SLL:  w_shift1 = {r_z[WIDTH-2:0], 1'b0};
         OP_SRL:  w_shift1 = {1'b0, r_z[WIDTH-1:1]};
         OP_SRA:  w_shift1 = {r_z[WIDTH-1], r_z[WIDTH-1:1]};
         default: w_shift1 = r_z;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_EXEC;
         end
         S_EXEC: begin
            if (w_is_shift && (w_amt != '0)) w_next = S_SHIFT;
            else                             w_next = S_DONE;
         end
         S_SHIFT: begin
            if (r_cnt == SW'(1)) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x   <= '0;
         r_y   <= '0;
         r_op  <= '0;
         r_cnt <= '0;
         r_z   <= '0;
         r_eq  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x  <= X;
                  r_y  <= Y;
                  r_op <= op_code;
               end
            end
            S_EXEC: begin
               r_z   <= w_res;
               r_eq  <= (r_x == r_y);
               r_ovf <= w_ovf;
               r_cnt <= w_amt;
            end
            S_SHIFT: begin
               r_z   <= w_shift1;
               r_cnt <= r_cnt - SW'(1);
            end
            default: ;
         endcase
      end
   end

   assign Z        = r_z;
   assign equal    = r_eq;
   assign overflow = r_ovf;
   assign zero     = (r_z == '0);

`ifdef ALU_STICKY_OVF_EN
   logic r_ovf_sticky;

   // clear has priority over a same-cycle overflowing transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ovf_sticky <= 1'b0;
      else if (ovf_clr)
         r_ovf_sticky <= 1'b0;
      else if (out_valid && out_ready && r_ovf)
         r_ovf_sticky <= 1'b1;
   end

   assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit.
// Checks results, flags, handshake latency, hold and mid-op reset.
module tb_alu_seq_unit;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_NOR = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_SLT = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd7;
   localparam logic [3:0] OP_SRL = 4'd8;
   localparam logic [3:0] OP_SRA = 4'd9;
   localparam logic [3:0] OP_BAD = 4'd15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] X = '0;
   logic [31:0] Y = '0;
   logic [3:0]  op_code = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] Z;
   logic        equal;
   logic        overflow;
   logic        zero;
`ifdef ALU_STICKY_OVF_EN
   logic        ovf_sticky;
   logic        ovf_clr = 1'b0;
`endif

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_seq_unit #(.WIDTH(32), .OP_WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .X          (X),
      .Y          (Y),
      .op_code    (op_code),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Z          (Z),
      .equal      (equal),
      .overflow   (overflow),
      .zero       (zero)
`ifdef ALU_STICKY_OVF_EN
      ,
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic chk_res(input string tag, input logic [31:0] z,
                          input logic eq, input logic ov);
      chk({tag, "_z"}, Z, z);
      chk({tag, "_eq"}, 32'(equal), 32'(eq));
      chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
      chk({tag, "_zero"}, 32'(zero), 32'(z == 32'd0));
   endtask

   // Accept one op, scramble inputs, then wait for out_valid
   task automatic issue(input string tag, input logic [3:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input int exp_lat);
      int lat;
      int rdy;
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      X = x;
      Y = y;
      op_code = op;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      X = ~x;
      Y = $urandom;
      op_code = op ^ 4'h3;
      lat = 0;
      rdy = 32'(in_ready);
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (!out_valid && in_ready) rdy++;
      end while (!out_valid && lat < 64);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, 32'(rdy), 32'd0);
   endtask

   task automatic take(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_z", Z, 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_eq", 32'(equal), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 32'(in_ready), 32'd1);

      issue("add", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1);
      chk_res("add", 32'h80000000, 1'b0, 1'b1);
      take("add");

      issue("sub0", OP_SUB, 32'h12345678, 32'h12345678, 1);
      chk_res("sub0", 32'h00000000, 1'b1, 1'b0);
      take("sub0");

      issue("subov", OP_SUB, 32'h80000000, 32'h00000001, 1);
      chk_res("subov", 32'h7FFFFFFF, 1'b0, 1'b1);
      take("subov");

      issue("sra", OP_SRA, 32'h80000000, 32'h00000004, 5);
      chk_res("sra", 32'hF8000000, 1'b0, 1'b0);
      take("sra");

      issue("srl31", OP_SRL, 32'h80000000, 32'h0000001F, 32);
      chk_res("srl31", 32'h00000001, 1'b0, 1'b0);
      take("srl31");

      issue("sll1", OP_SLL, 32'h00000003, 32'h00000001, 2);
      chk_res("sll1", 32'h00000006, 1'b0, 1'b0);
      take("sll1");

      issue("sll0", OP_SLL, 32'h0000ABCD, 32'h00000020, 1);
      chk_res("sll0", 32'h0000ABCD, 1'b0, 1'b0);
      take("sll0");

      issue("slt1", OP_SLT, 32'hFFFFFFFF, 32'h00000001, 1);
      chk_res("slt1", 32'h00000001, 1'b0, 1'b0);
      take("slt1");

      issue("slt0", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 1);
      chk_res("slt0", 32'h00000000, 1'b0, 1'b0);
      take("slt0");

      issue("or", OP_OR, 32'h0F0F0000, 32'h00F0F0F0, 1);
      chk_res("or", 32'h0FFFF0F0, 1'b0, 1'b0);
      take("or");

      issue("xor", OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 1);
      chk_res("xor", 32'hF0F00F0F, 1'b0, 1'b0);
      take("xor");

      issue("nor", OP_NOR, 32'h0F0F0F0F, 32'hF0F0F0F0, 1);
      chk_res("nor", 32'h00000000, 1'b0, 1'b0);
      take("nor");

      issue("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         X = 32'h11111111;
         Y = 32'h22222222;
         op_code = OP_ADD;
         @(posedge clk);
         #1;
         chk_res("and_hold", 32'hF000F000, 1'b0, 1'b0);
         chk("and_hold_ov", 32'(out_valid), 32'd1);
         chk("and_hold_rdy", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      take("and");

      issue("bad", OP_BAD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      chk_res("bad", 32'h00000000, 1'b1, 1'b0);
      take("bad");

      @(negedge clk);
      in_valid = 1'b1;
      X = 32'h00000001;
      Y = 32'h0000001F;
      op_code = OP_SLL;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_ov", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      chk("mid_rst_z", Z, 32'd0);
      chk("mid_rst_zero", 32'(zero), 32'd1);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue("post", OP_ADD, 32'd2, 32'd3, 1);
      chk_res("post", 32'd5, 1'b0, 1'b0);
      take("post");

`ifdef ALU_STICKY_OVF_EN
      chk("stk_init", 32'(ovf_sticky), 32'd0);
      issue("stk", OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
      chk("stk_pre", 32'(ovf_sticky), 32'd0);
      take("stk");
      chk("stk_set", 32'(ovf_sticky), 32'd1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      chk("stk_clr", 32'(ovf_sticky), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
